div_unit_param: RTL and testbench

- Parametrised successor to the core's single-channel 32-bit divide unit.
- Accepts RISC-V DIV/DIVU/REM/REMU requests into an input queue of configurable depth and runs them through an internal iterative radix-2 restoring divider.
- The divider skips leading-zero iterations and can reuse the previous quotient/remainder when operand magnitudes repeat.
- Sits behind issue and drives one writeback port with done/ack handshake.

---
 rtl/div_unit_param.sv | 180 ++++++++++++++++++
 tb/tb_div_unit_param.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/div_unit_param.sv
// Queued iterative radix-2 divider for RISC-V DIV/DIVU/REM/REMU.
// Leading-zero skip on the dividend, optional reuse of the last computed result.
module div_unit_param #(
    parameter int DATA_WIDTH   = 32,
    parameter int QUEUE_DEPTH  = 2,
    parameter int ID_WIDTH     = 3,
    parameter int ENABLE_REUSE = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  issue_valid,
    output logic                  issue_ready,
    input  logic [DATA_WIDTH-1:0] issue_rs1,
    input  logic [DATA_WIDTH-1:0] issue_rs2,
    input  logic [1:0]            issue_fn3,
    input  logic [ID_WIDTH-1:0]   issue_id,
    output logic                  wb_done,
    input  logic                  wb_ack,
    output logic [DATA_WIDTH-1:0] wb_rd,
    output logic [ID_WIDTH-1:0]   wb_id,
    output logic                  busy
);
    localparam int MSB = DATA_WIDTH - 1;
    localparam int CW  = $clog2(DATA_WIDTH) + 1;
    localparam int PW  = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int NW  = $clog2(QUEUE_DEPTH + 1);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] mag1;
        logic [DATA_WIDTH-1:0] mag2;
        logic [CW-1:0]         clz;
        logic                  dz;
        logic                  neg;
        logic                  rem;
        logic [ID_WIDTH-1:0]   id;
    } entry_t;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    logic   sgn;
    entry_t in_e;

    always_comb begin
        in_e = '0;
        sgn = ~issue_fn3[0];
        in_e.mag1 = (sgn && issue_rs1[MSB]) ? -issue_rs1 : issue_rs1;
        in_e.mag2 = (sgn && issue_rs2[MSB]) ? -issue_rs2 : issue_rs2;
        in_e.clz = CW'(DATA_WIDTH);
        for (int i = 0; i < DATA_WIDTH; i++) begin
            if (in_e.mag1[i]) in_e.clz = CW'(DATA_WIDTH - 1 - i);
        end
        in_e.dz  = (issue_rs2 == '0);
        in_e.rem = issue_fn3[1];
        in_e.neg = issue_fn3[1] ? (sgn & issue_rs1[MSB])
                 : (sgn & (issue_rs1[MSB] ^ issue_rs2[MSB]) & ~in_e.dz);
        in_e.id  = issue_id;
    end

    entry_t        mem [QUEUE_DEPTH];
    logic [PW-1:0] wptr, rptr;
    logic [NW-1:0] count;
    logic          empty, full, push, pop;
    entry_t        head;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(QUEUE_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    state_t                state, state_nx;
    logic [DATA_WIDTH-1:0] dvd, dsr, q, r, cur_mag1;
    logic [DATA_WIDTH-1:0] prev_mag1, prev_mag2, prev_q, prev_r;
    logic [CW-1:0]         cnt, head_n;
    logic                  reuse_valid, cur_neg, cur_rem, hit, head_fast;
    logic [ID_WIDTH-1:0]   cur_id;
    logic [DATA_WIDTH:0]   shifted, diff;
    logic                  ge;
    logic [DATA_WIDTH-1:0] q_nx, r_nx, res;

    assign empty = (count == '0);
    assign full  = (count == NW'(QUEUE_DEPTH));
    assign head  = mem[rptr];
    assign pop   = !empty && (state == IDLE || (state == DONE && wb_ack));
    assign push  = issue_valid && issue_ready;

    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= in_e;
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= ptr_inc(wptr);
            if (pop)  rptr <= ptr_inc(rptr);
            if (push && !pop)      count <= count + NW'(1);
            else if (!push && pop) count <= count - NW'(1);
        end
    end

    // A divide-by-zero never matches, since its divisor is never stored
    assign hit = (ENABLE_REUSE != 0) && reuse_valid && !head.dz &&
                 (head.mag1 == prev_mag1) && (head.mag2 == prev_mag2);
    assign head_n    = CW'(DATA_WIDTH) - head.clz;
    assign head_fast = head.dz || hit || (head_n == '0);

    always_comb begin
        shifted = {r, dvd[MSB]};
        diff    = shifted - {1'b0, dsr};
        ge      = (shifted >= {1'b0, dsr});
        r_nx    = ge ? diff[MSB:0] : shifted[MSB:0];
        q_nx    = {q[MSB-1:0], ge};
    end

    always_ff @(posedge clk) begin
        if (rst || flush) state <= IDLE;
        else              state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (pop) state_nx = head_fast ? DONE : CALC;
            CALC: if (cnt == CW'(1)) state_nx = DONE;
            DONE: if (wb_ack) state_nx = pop ? (head_fast ? DONE : CALC) : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        wb_done     = (state == DONE);
        busy        = !empty || (state != IDLE);
        issue_ready = !full || pop;
        res         = cur_rem ? r : q;
        wb_rd       = cur_neg ? -res : res;
        wb_id       = cur_id;
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            reuse_valid <= 1'b0;
        end else if (pop) begin
            cur_neg  <= head.neg;
            cur_rem  <= head.rem;
            cur_id   <= head.id;
            cur_mag1 <= head.mag1;
            dsr      <= head.mag2;
            cnt      <= head_n;
            unique case (1'b1)
                head.dz: begin
                    q <= '1;
                    r <= head.mag1;
                end
                hit: begin
                    q <= prev_q;
                    r <= prev_r;
                end
                default: begin
                    dvd <= head.mag1 << head.clz;
                    q   <= '0;
                    r   <= '0;
                end
            endcase
        end else if (state == CALC) begin
            r   <= r_nx;
            q   <= q_nx;
            dvd <= {dvd[MSB-1:0], 1'b0};
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1)) begin
                prev_mag1   <= cur_mag1;
                prev_mag2   <= dsr;
                prev_q      <= q_nx;
                prev_r      <= r_nx;
                reuse_valid <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_div_unit_param.sv
// Directed bench for div_unit_param: default 32-bit instance plus a
// 16-bit, single-entry, no-reuse instance.
module tb_div_unit_param;
    logic        clk = 1'b0;
    logic        rst, flush;
    logic        issue_valid, issue_ready, wb_done, wb_ack, busy;
    logic [31:0] issue_rs1, issue_rs2, wb_rd;
    logic [1:0]  issue_fn3;
    logic [2:0]  issue_id, wb_id;

    logic        b_valid, b_ready, b_done, b_ack, b_busy;
    logic [15:0] b_rs1, b_rs2, b_rd;
    logic [1:0]  b_fn3;
    logic [2:0]  b_id, b_wid;

    int          checks = 0;
    int          errors = 0;
    int          lat;
    logic [31:0] rd;
    logic [2:0]  rid;

    always #5 clk = ~clk;

    div_unit_param u_a (
        .clk(clk), .rst(rst), .flush(flush),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
        .issue_fn3(issue_fn3), .issue_id(issue_id),
        .wb_done(wb_done), .wb_ack(wb_ack),
        .wb_rd(wb_rd), .wb_id(wb_id), .busy(busy)
    );

    div_unit_param #(
        .DATA_WIDTH(16), .QUEUE_DEPTH(1), .ID_WIDTH(3), .ENABLE_REUSE(0)
    ) u_b (
        .clk(clk), .rst(rst), .flush(flush),
        .issue_valid(b_valid), .issue_ready(b_ready),
        .issue_rs1(b_rs1), .issue_rs2(b_rs2),
        .issue_fn3(b_fn3), .issue_id(b_id),
        .wb_done(b_done), .wb_ack(b_ack),
        .wb_rd(b_rd), .wb_id(b_wid), .busy(b_busy)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue into an idle unit; latency counted from the dequeue cycle
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input logic [1:0] fn, input logic [2:0] tid,
                          output int l, output logic [31:0] res,
                          output logic [2:0] oid);
        issue_valid = 1'b1;
        issue_rs1 = a;
        issue_rs2 = b;
        issue_fn3 = fn;
        issue_id = tid;
        tick;
        issue_valid = 1'b0;
        l = 0;
        while (!wb_done && l < 100) begin
            tick;
            l++;
        end
        res = wb_rd;
        oid = wb_id;
        wb_ack = 1'b1;
        tick;
        wb_ack = 1'b0;
    endtask

    task automatic run16(input logic [15:0] a, input logic [15:0] b,
                         input logic [1:0] fn, input logic [2:0] tid,
                         output int l, output logic [31:0] res);
        b_valid = 1'b1;
        b_rs1 = a;
        b_rs2 = b;
        b_fn3 = fn;
        b_id = tid;
        tick;
        b_valid = 1'b0;
        l = 0;
        while (!b_done && l < 100) begin
            tick;
            l++;
        end
        res = {16'h0, b_rd};
        b_ack = 1'b1;
        tick;
        b_ack = 1'b0;
    endtask

    task automatic wait_done(output int l);
        l = 0;
        do begin
            tick;
            l++;
        end while (!wb_done && l < 100);
    endtask

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        issue_valid = 1'b0;
        issue_rs1 = '0;
        issue_rs2 = '0;
        issue_fn3 = '0;
        issue_id = '0;
        wb_ack = 1'b0;
        b_valid = 1'b0;
        b_rs1 = '0;
        b_rs2 = '0;
        b_fn3 = '0;
        b_id = '0;
        b_ack = 1'b0;
        tick;
        tick;
        check("rst done", {31'h0, wb_done}, 32'd0);
        check("rst busy", {31'h0, busy}, 32'd0);
        check("rst ready", {31'h0, issue_ready}, 32'd1);
        check("rst b done", {31'h0, b_done}, 32'd0);
        check("rst b ready", {31'h0, b_ready}, 32'd1);
        rst = 1'b0;
        tick;

        run_op(32'd100, 32'd7, 2'd0, 3'd1, lat, rd, rid);
        check("div100_7 lat", lat, 32'd8);
        check("div100_7 rd", rd, 32'd14);
        check("div100_7 id", {29'h0, rid}, 32'd1);
        run_op(32'd100, 32'd7, 2'd2, 3'd2, lat, rd, rid);
        check("rem100_7 lat", lat, 32'd1);
        check("rem100_7 rd", rd, 32'd2);
        check("rem100_7 id", {29'h0, rid}, 32'd2);

        run_op(32'hFFFFFFF9, 32'd2, 2'd0, 3'd3, lat, rd, rid);
        check("div-7_2 lat", lat, 32'd4);
        check("div-7_2 rd", rd, 32'hFFFFFFFD);
        run_op(32'hFFFFFFF9, 32'd2, 2'd2, 3'd4, lat, rd, rid);
        check("rem-7_2 lat", lat, 32'd1);
        check("rem-7_2 rd", rd, 32'hFFFFFFFF);
        run_op(32'hFFFFFFF9, 32'd2, 2'd1, 3'd5, lat, rd, rid);
        check("divu lat", lat, 32'd33);
        check("divu rd", rd, 32'h7FFFFFFC);

        run_op(32'd5, 32'd0, 2'd0, 3'd6, lat, rd, rid);
        check("div5_0 lat", lat, 32'd1);
        check("div5_0 rd", rd, 32'hFFFFFFFF);
        run_op(32'd5, 32'd0, 2'd2, 3'd7, lat, rd, rid);
        check("rem5_0 lat", lat, 32'd1);
        check("rem5_0 rd", rd, 32'd5);

        run_op(32'h80000000, 32'hFFFFFFFF, 2'd0, 3'd0, lat, rd, rid);
        check("ovf div lat", lat, 32'd33);
        check("ovf div rd", rd, 32'h80000000);
        run_op(32'h80000000, 32'hFFFFFFFF, 2'd2, 3'd1, lat, rd, rid);
        check("ovf rem rd", rd, 32'd0);

        wb_ack = 1'b1;
        tick;
        wb_ack = 1'b0;
        check("idle ack done", {31'h0, wb_done}, 32'd0);
        check("idle ack busy", {31'h0, busy}, 32'd0);

        issue_valid = 1'b1;
        issue_fn3 = 2'd1;
        issue_rs1 = 32'd50;
        issue_rs2 = 32'd5;
        issue_id = 3'd1;
        tick;
        issue_rs1 = 32'd60;
        issue_rs2 = 32'd7;
        issue_id = 3'd2;
        tick;
        issue_rs1 = 32'd81;
        issue_rs2 = 32'd9;
        issue_id = 3'd3;
        tick;
        issue_valid = 1'b0;
        check("q full ready", {31'h0, issue_ready}, 32'd0);
        check("q full busy", {31'h0, busy}, 32'd1);
        lat = 0;
        while (!wb_done && lat < 100) begin
            tick;
            lat++;
        end
        check("q1 id", {29'h0, wb_id}, 32'd1);
        check("q1 rd", wb_rd, 32'd10);
        check("q1 ready held", {31'h0, issue_ready}, 32'd0);
        wb_ack = 1'b1;
        #1;
        check("q ack ready", {31'h0, issue_ready}, 32'd1);
        wait_done(lat);
        wb_ack = 1'b0;
        check("q2 lat", lat, 32'd7);
        check("q2 id", {29'h0, wb_id}, 32'd2);
        check("q2 rd", wb_rd, 32'd8);
        wb_ack = 1'b1;
        wait_done(lat);
        wb_ack = 1'b0;
        check("q3 lat", lat, 32'd8);
        check("q3 id", {29'h0, wb_id}, 32'd3);
        check("q3 rd", wb_rd, 32'd9);
        wb_ack = 1'b1;
        tick;
        wb_ack = 1'b0;
        check("q drained busy", {31'h0, busy}, 32'd0);

        issue_valid = 1'b1;
        issue_rs1 = 32'd1000;
        issue_rs2 = 32'd3;
        issue_id = 3'd4;
        tick;
        issue_rs1 = 32'd200;
        issue_id = 3'd5;
        tick;
        issue_rs1 = 32'd300;
        issue_rs2 = 32'd7;
        issue_id = 3'd6;
        tick;
        issue_valid = 1'b0;
        flush = 1'b1;
        tick;
        flush = 1'b0;
        check("flush done", {31'h0, wb_done}, 32'd0);
        check("flush busy", {31'h0, busy}, 32'd0);
        check("flush ready", {31'h0, issue_ready}, 32'd1);
        run_op(32'd81, 32'd9, 2'd1, 3'd7, lat, rd, rid);
        check("post flush lat", lat, 32'd8);
        check("post flush rd", rd, 32'd9);
        check("post flush id", {29'h0, rid}, 32'd7);

        run16(16'hFFFF, 16'h0003, 2'd1, 3'd2, lat, rd);
        check("w16 lat", lat, 32'd17);
        check("w16 rd", rd, 32'h5555);
        run16(16'hFFFF, 16'h0003, 2'd1, 3'd3, lat, rd);
        check("w16 repeat lat", lat, 32'd17);
        check("w16 repeat rd", rd, 32'h5555);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
